// File: rtl/line_sched_pkg.sv
// line_sched_pkg: state encoding and width helpers shared by line_scheduler and its counter
package line_sched_pkg;
  typedef enum logic [1:0] {IDLE, CHECK, ISSUE, DRAIN} state_e;
  localparam int ADDR_W = 20;
  localparam int DEF_H_DISP = 1280;
  localparam int DEF_V_DISP = 720;
  function automatic int coord_w(input int n);
    return $clog2(n) + 1;
  endfunction
  function automatic int occ_w(input int cw);
    return cw + 1;
  endfunction
endpackage

// File: rtl/line_scheduler_inflight_counter.sv
// inflight_counter: up/down counter of pixels issued but not yet retired, saturating at both ends
module inflight_counter #(
  parameter int W = 8
) (
  input  logic         PPL_clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count
);
  logic [W-1:0] count_q, count_d;
  always_comb
    count_d = (inc & ~dec & ~&count_q) ? count_q + 1'b1 :
              (dec & ~inc & |count_q)  ? count_q - 1'b1 : count_q;
  always_ff @(posedge PPL_clk or negedge rst_n)
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  assign count = count_q;
endmodule

// File: rtl/line_scheduler.sv
// line_scheduler: raster-order pixel issue gated by line-FIFO credit (fill + in-flight).
// Define LINE_SCHED_STATS_EN to build the frame/stall cycle counters; otherwise they read 0.
module line_scheduler
  import line_sched_pkg::*;
#(
  parameter int H_DISP     = DEF_H_DISP,
  parameter int V_DISP     = DEF_V_DISP,
  parameter int FIFO_DEPTH = H_DISP + 64,
  parameter int CW         = $clog2(H_DISP + 64) + 1
) (
  input  logic                         PPL_clk,
  input  logic                         rst_n,
  input  logic                         frame_start,
  input  logic [CW-1:0]                fifo_wr_count,
  input  logic                         ppl_ready,
  input  logic                         ret_valid,
  output logic                         pix_valid,
  output logic [coord_w(H_DISP)-1:0]   pix_x,
  output logic [coord_w(V_DISP)-1:0]   pix_y,
  output logic [ADDR_W-1:0]            pix_addr,
  output logic                         busy,
  output logic                         frame_done,
  output logic                         overrun,
  output logic [31:0]                  frame_cycles,
  output logic [31:0]                  stall_cycles
);
  localparam int XW = coord_w(H_DISP);
  localparam int YW = coord_w(V_DISP);
  localparam int OW = occ_w(CW);

  state_e              state_q, state_d;
  logic [XW-1:0]       x_q, x_d;
  logic [YW-1:0]       y_q, y_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                pix_valid_q, busy_q, done_q, done_d, overrun_q, overrun_d;
  logic [CW-1:0]       inflight;
  logic [OW-1:0]       occ;
  logic                xfer, start, credit_ok;

  assign xfer  = pix_valid_q & ppl_ready;
  assign start = frame_start & (state_q == IDLE);
  assign occ   = OW'(fifo_wr_count) + OW'(inflight);
  // Credit covers a whole line so a started line never has to wait on FIFO space.
  assign credit_ok = (32'(occ) + 32'(H_DISP)) <= 32'(FIFO_DEPTH);

  inflight_counter #(.W(CW)) u_inflight (
    .PPL_clk (PPL_clk),
    .rst_n   (rst_n),
    .inc     (xfer),
    .dec     (ret_valid),
    .count   (inflight)
  );

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    addr_d    = addr_q;
    done_d    = 1'b0;
    overrun_d = overrun_q | (frame_start & (state_q != IDLE));
    case (state_q)
      IDLE: if (frame_start) begin
        state_d = CHECK;
        x_d     = '0;
        y_d     = '0;
        addr_d  = '0;
      end
      CHECK: if (credit_ok) state_d = ISSUE;
      ISSUE: if (xfer) begin
        addr_d = addr_q + 1'b1;
        if (x_q == XW'(H_DISP - 1)) begin
          x_d = '0;
          if (y_q == YW'(V_DISP - 1)) state_d = DRAIN;
          else begin
            y_d     = y_q + 1'b1;
            state_d = CHECK;
          end
        end else x_d = x_q + 1'b1;
      end
      DRAIN: if (inflight == '0) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PPL_clk or negedge rst_n)
    if (!rst_n) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      addr_q      <= '0;
      pix_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      addr_q      <= addr_d;
      pix_valid_q <= state_d == ISSUE;
      busy_q      <= state_d != IDLE;
      done_q      <= done_d;
      overrun_q   <= overrun_d;
    end

  assign pix_valid  = pix_valid_q;
  assign pix_x      = x_q;
  assign pix_y      = y_q;
  assign pix_addr   = addr_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign overrun    = overrun_q;

`ifdef LINE_SCHED_STATS_EN
  logic [31:0] frame_cycles_q, frame_cycles_d, stall_cycles_q, stall_cycles_d;
  logic        stall;
  always_comb begin
    stall          = (state_q == CHECK) | (pix_valid_q & ~ppl_ready);
    frame_cycles_d = start ? '0 : (busy_q & ~&frame_cycles_q) ? frame_cycles_q + 32'd1 : frame_cycles_q;
    stall_cycles_d = start ? '0 : (stall & ~&stall_cycles_q) ? stall_cycles_q + 32'd1 : stall_cycles_q;
  end
  always_ff @(posedge PPL_clk or negedge rst_n)
    if (!rst_n) begin
      frame_cycles_q <= '0;
      stall_cycles_q <= '0;
    end else begin
      frame_cycles_q <= frame_cycles_d;
      stall_cycles_q <= stall_cycles_d;
    end
  assign frame_cycles = frame_cycles_q;
  assign stall_cycles = stall_cycles_q;
`else
  assign frame_cycles = '0;
  assign stall_cycles = '0;
`endif
endmodule

// File: tb/tb_line_scheduler.sv
// tb_line_scheduler: directed scenarios with a pixel scoreboard and a 3-cycle retire echo
module tb_line_scheduler;
  localparam int H = 8, V = 4, DEPTH = 12, CW = $clog2(H + 64) + 1;
  logic PPL_clk = 0, rst_n = 0, frame_start = 0, ppl_ready = 0, ret_valid = 0;
  logic [CW-1:0] fifo_wr_count = '0;
  logic pix_valid, busy, frame_done, overrun;
  logic [3:0] pix_x;
  logic [2:0] pix_y;
  logic [19:0] pix_addr;
  logic [31:0] frame_cycles, stall_cycles;
  int errors = 0, checks = 0, xfer_n = 0, done_n = 0, stall_n = 0;
  typedef struct {int x; int y; int addr;} pix_t;
  pix_t exp_q[$];

  always #5 PPL_clk = ~PPL_clk;

  line_scheduler #(.H_DISP(H), .V_DISP(V), .FIFO_DEPTH(DEPTH), .CW(CW)) dut (
    .PPL_clk(PPL_clk), .rst_n(rst_n), .frame_start(frame_start),
    .fifo_wr_count(fifo_wr_count), .ppl_ready(ppl_ready), .ret_valid(ret_valid),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_addr(pix_addr),
    .busy(busy), .frame_done(frame_done), .overrun(overrun),
    .frame_cycles(frame_cycles), .stall_cycles(stall_cycles)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge PPL_clk);
    #1;
  endtask

  task automatic start_frame();
    xfer_n = 0;
    done_n = 0;
    stall_n = 0;
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++) exp_q.push_back('{x, y, y * H + x});
    frame_start = 1;
    tick();
    frame_start = 0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 500 && done_n == 0; i++) tick();
    check({tag, "_done_seen"}, done_n, 1);
    check({tag, "_done_pulse_low"}, frame_done, 0);
    check({tag, "_busy_low"}, busy, 0);
    repeat (3) tick();
    check({tag, "_done_once"}, done_n, 1);
    check({tag, "_xfers"}, xfer_n, 32);
    check({tag, "_sb_empty"}, exp_q.size(), 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_valid"}, pix_valid, 0);
    check({tag, "_x"}, pix_x, 0);
    check({tag, "_y"}, pix_y, 0);
    check({tag, "_addr"}, pix_addr, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, frame_done, 0);
    check({tag, "_overrun"}, overrun, 0);
    check({tag, "_fcyc"}, frame_cycles, 0);
    check({tag, "_scyc"}, stall_cycles, 0);
  endtask

  // Monitor: scoreboard pops, stall-hold checks, retire echo
  initial begin
    logic [2:0] sh;
    logic prev_stall;
    logic [3:0] px;
    logic [2:0] py;
    logic [19:0] pa;
    pix_t e;
    sh = '0;
    prev_stall = 0;
    px = '0;
    py = '0;
    pa = '0;
    forever begin
      @(negedge PPL_clk);
      if (prev_stall && pix_valid) begin
        check("hold_x", pix_x, px);
        check("hold_y", pix_y, py);
        check("hold_addr", pix_addr, pa);
      end
      prev_stall = pix_valid & ~ppl_ready;
      px = pix_x;
      py = pix_y;
      pa = pix_addr;
      if (pix_valid && !ppl_ready) stall_n++;
      if (frame_done) done_n++;
      if (pix_valid && ppl_ready) begin
        xfer_n++;
        check("sb_nonempty", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("pix_x", pix_x, e.x);
          check("pix_y", pix_y, e.y);
          check("pix_addr", pix_addr, e.addr);
        end
      end
      ret_valid = sh[2];
      sh = {sh[1:0], pix_valid & ppl_ready};
    end
  end

  initial begin
    repeat (3) tick();
    check_reset_vals("reset");
    rst_n = 1;
    tick();

    // Full frame, with exact start latency and line-boundary bubble
    ppl_ready = 1;
    start_frame();
    check("ff_busy_n1", busy, 1);
    check("ff_valid_n1", pix_valid, 0);
    tick();
    check("ff_valid_n2", pix_valid, 1);
    check("ff_addr_first", pix_addr, 0);
    repeat (8) tick();
    check("ff_bubble", pix_valid, 0);
    tick();
    check("ff_line1_valid", pix_valid, 1);
    check("ff_line1_y", pix_y, 1);
    check("ff_line1_addr", pix_addr, 8);
    wait_done("ff");
`ifdef LINE_SCHED_STATS_EN
    check("ff_frame_cycles", frame_cycles, 40);
    check("ff_stall_cycles", stall_cycles, 4);
`else
    check("ff_frame_cycles", frame_cycles, 0);
    check("ff_stall_cycles", stall_cycles, 0);
`endif

    // Credit stall: 5 + 8 > 12 holds CHECK, 4 + 8 fits
    fifo_wr_count = 5;
    start_frame();
    for (int i = 0; i < 6; i++) begin
      check("cs_hold_valid", pix_valid, 0);
      tick();
    end
    check("cs_busy", busy, 1);
    fifo_wr_count = 4;
    tick();
    check("cs_issue_valid", pix_valid, 1);
    check("cs_issue_addr", pix_addr, 0);
    fifo_wr_count = 0;
    wait_done("cs");

    // Backpressure: ppl_ready toggles each cycle
    start_frame();
    for (int i = 0; i < 500 && done_n == 0; i++) begin
      ppl_ready = ~ppl_ready;
      tick();
    end
    ppl_ready = 1;
    wait_done("bp");
    check("bp_stalls_seen", stall_n > 0, 1);
`ifdef LINE_SCHED_STATS_EN
    check("bp_stall_cycles", stall_cycles, stall_n + 4);
`else
    check("bp_stall_cycles", stall_cycles, 0);
`endif

    // Overrun: second frame_start while issuing
    check("ov_clear_before", overrun, 0);
    start_frame();
    repeat (4) tick();
    frame_start = 1;
    tick();
    frame_start = 0;
    check("ov_set", overrun, 1);
    wait_done("ov");
    check("ov_sticky", overrun, 1);

    // Reset mid-frame at pixel 10
    start_frame();
    for (int i = 0; i < 200 && xfer_n < 10; i++) tick();
    check("rst_reached_px10", xfer_n, 10);
    #2 rst_n = 0;
    #1;
    check_reset_vals("midrst");
    exp_q.delete();
    repeat (5) tick();
    rst_n = 1;
    tick();
    start_frame();
    tick();
    check("rst_restart_valid", pix_valid, 1);
    check("rst_restart_addr", pix_addr, 0);
    wait_done("rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/line_scheduler.md
# line_scheduler

Render-side line scheduler in the `PPL_clk` domain, upstream of the pixel pipeline and sort stage that feed the video line FIFO. On each frame start it issues pixel coordinates and linear addresses in raster order, one line per burst. It admits a line only when the line FIFO has room for it, counting both the FIFO's reported fill and pixels still in flight in the pipeline. This keeps the FIFO from ever overflowing, so the video-side reader always finds complete lines.

## Interface
- `H_DISP`, 1280, active pixels per line
- `V_DISP`, 720, active lines per frame
- `FIFO_DEPTH`, `H_DISP+64`, line FIFO capacity in words
- `CW`, `$clog2(H_DISP+64)+1`, width of the FIFO write-count input
- `PPL_clk`  in  1  pipeline clock; all logic is on its rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `frame_start`  in  1  single-cycle pulse that requests one frame
- `fifo_wr_count`  in  CW  line FIFO fill level, write side
- `ppl_ready`  in  1  pipeline accepts the issued pixel this cycle
- `ret_valid`  in  1  one pixel retired into the FIFO (pipeline output valid)
- `pix_valid`  out  1  issued pixel is valid
- `pix_x`  out  `$clog2(H_DISP)+1`  column
- `pix_y`  out  `$clog2(V_DISP)+1`  row
- `pix_addr`  out  20  linear address, y*H_DISP+x
- `busy`  out  1  high from the accepted `frame_start` until `frame_done`
- `frame_done`  out  1  single-cycle pulse after the last pixel retires
- `overrun`  out  1  sticky; set when `frame_start` arrives while busy
- `frame_cycles`, `stall_cycles`  out  32 each  statistics (see Configuration)

## Operation
- States: IDLE, CHECK, ISSUE, DRAIN.
- IDLE
  - An accepted `frame_start` clears x, y and addr, then moves to CHECK.
- CHECK
  - `occ = fifo_wr_count + inflight`, computed at CW+1 bits with no truncation.
  - Move to ISSUE when `occ + H_DISP <= FIFO_DEPTH`; otherwise stay in CHECK.
- ISSUE
  - `pix_valid` is high.
  - A transfer occurs when `pix_valid & ppl_ready`. On each transfer: x+1, addr+1, inflight+1.
  - On a transfer at `x == H_DISP-1`:
    - x returns to 0.
    - If `y == V_DISP-1`, move to DRAIN.
    - Otherwise y+1 and move to CHECK.
- DRAIN
  - When `inflight == 0`, pulse `frame_done` and move to IDLE.
- `inflight`
  - Increments on a transfer and decrements on `ret_valid`.
  - When both occur in the same cycle it is unchanged.
  - `ret_valid` with `inflight == 0` is ignored (saturates at 0).
- `pix_addr` is incremented, never multiplied. This requires `H_DISP*V_DISP <= 2^20`.
- `frame_start` outside IDLE is ignored and sets `overrun`. `overrun` clears only on reset.

## Timing
- Reset values:
  - `pix_valid`=0, `pix_x`=0, `pix_y`=0, `pix_addr`=0
  - `busy`=0, `frame_done`=0, `overrun`=0
  - counters=0, state=IDLE
  - An assertion mid-frame aborts immediately with no drain.
- All outputs are registered.
- `frame_start` sampled high at edge n:
  - `busy` is high at n+1.
  - The first `pix_valid` is high at n+2 if credit is available.
- Back-to-back issue within a line: one pixel per cycle while `ppl_ready` is high.
- Line boundary: 1 bubble cycle (the CHECK state) between the last pixel of a line and the first pixel of the next.
- Stall: while `pix_valid=1` and `ppl_ready=0`, `pix_x`, `pix_y` and `pix_addr` hold stable.
- `frame_done` is high for exactly one cycle, the cycle after `inflight` reaches 0 in DRAIN. `busy` falls in that same cycle.

## Configuration
- `LINE_SCHED_STATS_EN` defined:
  - `frame_cycles` counts cycles while `busy`.
  - `stall_cycles` counts cycles in CHECK or with `pix_valid & ~ppl_ready`.
  - Both clear on an accepted `frame_start`, hold after `frame_done`, and saturate at all-ones.
- Not defined: both outputs are tied to 0 and no counter logic is built.

## Structure
- Package `line_sched_pkg` holds:
  - the state enum (IDLE, CHECK, ISSUE, DRAIN);
  - localparams for the coordinate and occupancy widths;
  - the address width of 20.
- Sub-module `inflight_counter` implements the up/down saturating counter, with inputs inc, dec and output count.

## Test plan
- Parameters for the bench: `H_DISP=8`, `V_DISP=4`, `FIFO_DEPTH=12`.
- Full frame:
  - Stimulus: `ppl_ready=1`, `ret_valid` echoes each issue 3 cycles later, `fifo_wr_count=0`, then one `frame_start`.
  - Response: 32 transfers, addr 0..31 in raster order, `frame_done` pulses once.
- Credit stall:
  - Stimulus: `fifo_wr_count=5`.
  - Response: the block holds in CHECK with `pix_valid=0`. When the count drops to 4, issue starts 1 cycle later.
- Backpressure:
  - Stimulus: `ppl_ready` toggled 1/0.
  - Response: `pix_x`/`pix_addr` hold during each low; no pixel is skipped or duplicated.
- Overrun:
  - Stimulus: a second `frame_start` during ISSUE.
  - Response: it is ignored, `overrun=1`, and the frame still completes with 32 transfers.
- Reset mid-frame:
  - Stimulus: `rst_n` low at pixel 10.
  - Response: all outputs are at reset values in the same cycle. A new frame afterwards starts again at addr 0.
- Stats (with `LINE_SCHED_STATS_EN`):
  - Stimulus: the backpressure case.
  - Response: `stall_cycles` equals the number of `ppl_ready=0` cycles while valid, plus the CHECK cycles.
